// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR request arbiter: command type codes,
// FSM state encoding and requester id width.
package ddr_arb_pkg;

    localparam logic CMD_WT = 1'b0;
    localparam logic CMD_RD = 1'b1;

    localparam int ID_W = 1;
    typedef logic [ID_W-1:0] rq_id_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rd_order_fifo.sv
// In-order tracker of outstanding reads: each entry holds {owner id, burst_cnt}.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module rd_order_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BCNT_W = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  rq_id_t                  push_id,
    input  logic [BCNT_W-1:0]       push_bcnt,
    input  logic                    pop,
    output rq_id_t                  head_id,
    output logic [BCNT_W-1:0]       head_bcnt,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    rq_id_t            id_mem   [DEPTH];
    logic [BCNT_W-1:0] bcnt_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr[PTR_W-2:0]]   <= push_id;
            bcnt_mem[wr_ptr[PTR_W-2:0]] <= push_bcnt;
        end
    end

    assign head_id   = id_mem[rd_ptr[PTR_W-2:0]];
    assign head_bcnt = bcnt_mem[rd_ptr[PTR_W-2:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/ddr_req_arbiter.sv
// Two-requester arbiter sharing the DDR3 command/response FIFO port; write bursts lock the grant.
// Build option ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
//   state   | meaning
//   ST_IDLE | grant picked each cycle among valid requesters
//   ST_LOCK | multi-beat write in progress, only the owner is forwarded
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W   = 27,
    parameter int DATA_W   = 128,
    parameter int MASK_W   = 16,
    parameter int BCNT_W   = 6,
    parameter int OT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rq0_cmd_valid,
    output logic              rq0_cmd_ready,
    input  logic              rq0_cmd_type,
    input  logic [ADDR_W-1:0] rq0_cmd_addr,
    input  logic [BCNT_W-1:0] rq0_cmd_burst_cnt,
    input  logic [DATA_W-1:0] rq0_cmd_wt_data,
    input  logic [MASK_W-1:0] rq0_cmd_wt_mask,
    output logic              rq0_rsp_valid,
    input  logic              rq0_rsp_ready,
    output logic [DATA_W-1:0] rq0_rsp_data,
    input  logic              rq1_cmd_valid,
    output logic              rq1_cmd_ready,
    input  logic              rq1_cmd_type,
    input  logic [ADDR_W-1:0] rq1_cmd_addr,
    input  logic [BCNT_W-1:0] rq1_cmd_burst_cnt,
    input  logic [DATA_W-1:0] rq1_cmd_wt_data,
    input  logic [MASK_W-1:0] rq1_cmd_wt_mask,
    output logic              rq1_rsp_valid,
    input  logic              rq1_rsp_ready,
    output logic [DATA_W-1:0] rq1_rsp_data,
    output logic              io_fifo_cmd_valid,
    input  logic              io_fifo_cmd_ready,
    output logic              io_fifo_cmd_type,
    output logic [ADDR_W-1:0] io_fifo_cmd_addr,
    output logic [BCNT_W-1:0] io_fifo_cmd_burst_cnt,
    output logic [DATA_W-1:0] io_fifo_cmd_wt_data,
    output logic [MASK_W-1:0] io_fifo_cmd_wt_mask,
    input  logic              io_fifo_rsp_valid,
    output logic              io_fifo_rsp_ready,
    input  logic [DATA_W-1:0] io_fifo_rsp_data,
    output logic              err_orphan
);
    localparam int PTR_W = $clog2(OT_DEPTH) + 1;

    arb_state_t        state, state_nxt;
    rq_id_t            grant, owner, tie_winner, head_id;
    logic [BCNT_W-1:0] remain, beat_cnt, head_bcnt, sel_bcnt;
    logic              sel_valid, sel_type, cmd_hs, load_lock, dec_lock;
    logic              trk_push, trk_pop, trk_full, trk_empty, rsp_hs;
    logic [PTR_W-1:0]  trk_count;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    rq_id_t last_grant;

    // A command finishes whenever a handshake leaves the FSM in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_grant <= 1'b1;
        else if (cmd_hs && state_nxt == ST_IDLE)
            last_grant <= grant;
    end

    assign tie_winner = ~last_grant;
`endif

    always_comb begin
        grant = owner;
        if (state == ST_IDLE) begin
            if (rq0_cmd_valid && rq1_cmd_valid)
                grant = tie_winner;
            else
                grant = rq_id_t'(rq1_cmd_valid);
        end
    end

    assign sel_valid = grant ? rq1_cmd_valid     : rq0_cmd_valid;
    assign sel_type  = grant ? rq1_cmd_type      : rq0_cmd_type;
    assign sel_bcnt  = grant ? rq1_cmd_burst_cnt : rq0_cmd_burst_cnt;

    assign io_fifo_cmd_valid     = sel_valid && !(sel_type == CMD_RD && trk_full);
    assign io_fifo_cmd_type      = sel_type;
    assign io_fifo_cmd_addr      = grant ? rq1_cmd_addr    : rq0_cmd_addr;
    assign io_fifo_cmd_burst_cnt = sel_bcnt;
    assign io_fifo_cmd_wt_data   = grant ? rq1_cmd_wt_data : rq0_cmd_wt_data;
    assign io_fifo_cmd_wt_mask   = grant ? rq1_cmd_wt_mask : rq0_cmd_wt_mask;

    assign cmd_hs        = io_fifo_cmd_valid && io_fifo_cmd_ready;
    assign rq0_cmd_ready = cmd_hs && (grant == 1'b0);
    assign rq1_cmd_ready = cmd_hs && (grant == 1'b1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_hs && sel_type == CMD_WT && sel_bcnt != '0) state_nxt = ST_LOCK;
            ST_LOCK: if (cmd_hs && remain == BCNT_W'(1))                  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_lock = 1'b0;
        dec_lock  = 1'b0;
        case (state)
            ST_IDLE: load_lock = (state_nxt == ST_LOCK);
            ST_LOCK: dec_lock  = cmd_hs;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner  <= '0;
            remain <= '0;
        end else if (load_lock) begin
            owner  <= grant;
            remain <= sel_bcnt;
        end else if (dec_lock) begin
            remain <= remain - BCNT_W'(1);
        end
    end

    assign trk_push = cmd_hs && sel_type == CMD_RD;

    rd_order_fifo #(
        .DEPTH  (OT_DEPTH),
        .BCNT_W (BCNT_W)
    ) u_rd_order_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (trk_push),
        .push_id   (grant),
        .push_bcnt (sel_bcnt),
        .pop       (trk_pop),
        .head_id   (head_id),
        .head_bcnt (head_bcnt),
        .full      (trk_full),
        .empty     (trk_empty),
        .count     (trk_count)
    );

    // With nothing outstanding, beats are swallowed so the bridge never wedges.
    always_comb begin
        rq0_rsp_valid     = 1'b0;
        rq1_rsp_valid     = 1'b0;
        io_fifo_rsp_ready = io_fifo_rsp_valid;
        if (!trk_empty) begin
            if (head_id == 1'b1) begin
                rq1_rsp_valid     = io_fifo_rsp_valid;
                io_fifo_rsp_ready = rq1_rsp_ready;
            end else begin
                rq0_rsp_valid     = io_fifo_rsp_valid;
                io_fifo_rsp_ready = rq0_rsp_ready;
            end
        end
    end

    assign rq0_rsp_data = io_fifo_rsp_data;
    assign rq1_rsp_data = io_fifo_rsp_data;
    assign rsp_hs       = io_fifo_rsp_valid && io_fifo_rsp_ready && !trk_empty;
    assign trk_pop      = rsp_hs && (beat_cnt == head_bcnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (trk_pop)
                beat_cnt <= '0;
            else if (rsp_hs)
                beat_cnt <= beat_cnt + BCNT_W'(1);
            if (io_fifo_rsp_valid && trk_empty)
                err_orphan <= 1'b1;
        end
    end

    a_trk_bound: assert property (@(posedge clk) disable iff (!rstn) trk_count <= PTR_W'(OT_DEPTH));

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant, tracker and steering rules.
module tb_ddr_req_arbiter;
    import ddr_arb_pkg::*;

    localparam int ADDR_W   = 27;
    localparam int DATA_W   = 128;
    localparam int MASK_W   = 16;
    localparam int BCNT_W   = 6;
    localparam int OT_DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]        cv, ct, rr;
    logic [ADDR_W-1:0] ca [2];
    logic [BCNT_W-1:0] cb [2];
    logic [DATA_W-1:0] cd [2];
    logic [MASK_W-1:0] cm [2];
    wire               cr0, cr1, rv0, rv1;
    wire [DATA_W-1:0]  rd0, rd1;
    wire               fcv, fct, frr, err;
    wire [ADDR_W-1:0]  fca;
    wire [BCNT_W-1:0]  fcb;
    wire [DATA_W-1:0]  fcd;
    wire [MASK_W-1:0]  fcm;
    logic              fcr, frv;
    logic [DATA_W-1:0] frd;

    int checks = 0;
    int errors = 0;

    ddr_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BCNT_W(BCNT_W), .OT_DEPTH(OT_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rq0_cmd_valid(cv[0]), .rq0_cmd_ready(cr0), .rq0_cmd_type(ct[0]), .rq0_cmd_addr(ca[0]),
        .rq0_cmd_burst_cnt(cb[0]), .rq0_cmd_wt_data(cd[0]), .rq0_cmd_wt_mask(cm[0]),
        .rq0_rsp_valid(rv0), .rq0_rsp_ready(rr[0]), .rq0_rsp_data(rd0),
        .rq1_cmd_valid(cv[1]), .rq1_cmd_ready(cr1), .rq1_cmd_type(ct[1]), .rq1_cmd_addr(ca[1]),
        .rq1_cmd_burst_cnt(cb[1]), .rq1_cmd_wt_data(cd[1]), .rq1_cmd_wt_mask(cm[1]),
        .rq1_rsp_valid(rv1), .rq1_rsp_ready(rr[1]), .rq1_rsp_data(rd1),
        .io_fifo_cmd_valid(fcv), .io_fifo_cmd_ready(fcr), .io_fifo_cmd_type(fct),
        .io_fifo_cmd_addr(fca), .io_fifo_cmd_burst_cnt(fcb), .io_fifo_cmd_wt_data(fcd),
        .io_fifo_cmd_wt_mask(fcm), .io_fifo_rsp_valid(frv), .io_fifo_rsp_ready(frr),
        .io_fifo_rsp_data(frd), .err_orphan(err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        cv = '0; ct = '0; rr = '0; fcr = 1'b0; frv = 1'b0; frd = '0;
        for (int i = 0; i < 2; i++) begin
            ca[i] = '0; cb[i] = '0; cd[i] = '0; cm[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        cyc(); cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        cyc(); settle();
        checks++;
        if ({fcv, cr0, cr1, rv0, rv1, frr, err} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000000", {fcv, cr0, cr1, rv0, rv1, frr, err});
        end
        rstn = 1'b1;
        cyc(); settle();
        checks++;
        if ({fcv, cr0, cr1, rv0, rv1, frr, err} !== 7'b0) begin
            errors++; $display("FAIL release_outputs: got %b expected 0000000", {fcv, cr0, cr1, rv0, rv1, frr, err});
        end
    endtask

    task automatic test_contention();
        logic [DATA_W-1:0] d0, d1;
        d0 = {$urandom, $urandom, $urandom, $urandom};
        d1 = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        cv = 2'b11; ct = 2'b11; ca[0] = 27'h100; ca[1] = 27'h200; fcr = 1'b1;
        settle();
        checks++;
        if ({cr1, cr0} !== 2'b01 || fca !== 27'h100 || fct !== CMD_RD) begin
            errors++; $display("FAIL contention_first: ready=%b addr=%h expected ready=01 addr=100", {cr1, cr0}, fca);
        end
        cyc(); cv[0] = 1'b0; settle();
        checks++;
        if ({cr1, cr0} !== 2'b10 || fca !== 27'h200) begin
            errors++; $display("FAIL contention_second: ready=%b addr=%h expected ready=10 addr=200", {cr1, cr0}, fca);
        end
        cyc(); cv = '0; fcr = 1'b0; frv = 1'b1; frd = d0; rr = 2'b11; settle();
        checks++;
        if ({rv1, rv0} !== 2'b01 || rd0 !== d0 || frr !== 1'b1) begin
            errors++; $display("FAIL contention_rsp0: valid=%b data=%h ready=%b expected valid=01 data=%h ready=1", {rv1, rv0}, rd0, frr, d0);
        end
        cyc(); frd = d1; settle();
        checks++;
        if ({rv1, rv0} !== 2'b10 || rd1 !== d1) begin
            errors++; $display("FAIL contention_rsp1: valid=%b data=%h expected valid=10 data=%h", {rv1, rv0}, rd1, d1);
        end
        cyc(); frv = 1'b0; rr = '0; settle();
        checks++;
        if ({rv1, rv0, frr, err} !== 4'b0) begin
            errors++; $display("FAIL contention_drained: got %b expected 0000", {rv1, rv0, frr, err});
        end
        idle();
    endtask

    task automatic test_locked_write();
        logic [DATA_W-1:0] wd [4];
        for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        fcr = 1'b1;
        cv = 2'b10; ct[1] = CMD_WT; ca[1] = 27'h3A0; cb[1] = 6'd3; cm[1] = 16'hF0F0;
        ct[0] = CMD_RD; ca[0] = 27'h040; cb[0] = '0;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                fcr = 1'b0; settle();
                checks++;
                if ({cr1, cr0} !== 2'b00 || fca !== 27'h3A0) begin
                    errors++; $display("FAIL lock_stall: ready=%b addr=%h expected ready=00 addr=3a0", {cr1, cr0}, fca);
                end
                cyc(); fcr = 1'b1;
            end
            cd[1] = wd[b]; settle();
            checks++;
            if ({cr1, cr0} !== 2'b10 || fct !== CMD_WT || fca !== 27'h3A0 || fcd !== wd[b] || fcm !== 16'hF0F0) begin
                errors++; $display("FAIL lock_beat%0d: ready=%b addr=%h data=%h expected ready=10 addr=3a0 data=%h", b, {cr1, cr0}, fca, fcd, wd[b]);
            end
            cyc(); cv[0] = 1'b1;
        end
        ct[1] = CMD_RD; ca[1] = 27'h500; cb[1] = '0; settle();
        checks++;
        if ({cr1, cr0} !== 2'b01 || fca !== 27'h040) begin
            errors++; $display("FAIL lock_release: ready=%b addr=%h expected ready=01 addr=040", {cr1, cr0}, fca);
        end
        cyc(); cv[0] = 1'b0; settle();
        checks++;
        if ({cr1, cr0} !== 2'b10 || fca !== 27'h500) begin
            errors++; $display("FAIL lock_after: ready=%b addr=%h expected ready=10 addr=500", {cr1, cr0}, fca);
        end
        cyc(); idle();
    endtask

    task automatic test_tracker_full();
        do_reset();
        fcr = 1'b1; cv = 2'b01; ct[0] = CMD_RD; cb[0] = 6'd1;
        for (int i = 0; i < 4; i++) begin
            ca[0] = ADDR_W'(32'h1000 + i * 8); settle();
            checks++;
            if (cr0 !== 1'b1) begin
                errors++; $display("FAIL full_fill%0d: ready=%b expected 1", i, cr0);
            end
            cyc();
        end
        ca[0] = 27'h2000;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (cr0 !== 1'b0 || fcv !== 1'b0) begin
                errors++; $display("FAIL full_stall%0d: ready=%b valid=%b expected 0 0", i, cr0, fcv);
            end
            cyc();
        end
        frv = 1'b1; rr[0] = 1'b1; frd = {4{32'hA5A5_0001}}; settle();
        checks++;
        if (cr0 !== 1'b0 || rv0 !== 1'b1 || frr !== 1'b1) begin
            errors++; $display("FAIL full_beat1: cmd_ready=%b rsp_valid=%b rsp_ready=%b expected 0 1 1", cr0, rv0, frr);
        end
        cyc(); frd = {4{32'hA5A5_0002}}; settle();
        checks++;
        if (cr0 !== 1'b0) begin
            errors++; $display("FAIL full_pop_cycle: ready=%b expected 0", cr0);
        end
        cyc(); frv = 1'b0; settle();
        checks++;
        if (cr0 !== 1'b1 || fca !== 27'h2000) begin
            errors++; $display("FAIL full_fifth_accept: ready=%b addr=%h expected 1 2000", cr0, fca);
        end
        cyc(); idle();
    endtask

    task automatic test_rsp_backpressure();
        logic [DATA_W-1:0] bd [4];
        logic [DATA_W-1:0] got [$];
        int idx = 0;
        for (int i = 0; i < 4; i++) bd[i] = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        fcr = 1'b1; cv = 2'b01; ct[0] = CMD_RD; ca[0] = 27'h77; cb[0] = 6'd3;
        cyc(); cv = '0; fcr = 1'b0;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            frv = 1'b1; frd = bd[idx]; rr[0] = !(c >= 2 && c < 5); settle();
            if (c >= 2 && c < 5) begin
                checks++;
                if (frr !== 1'b0 || rv0 !== 1'b1) begin
                    errors++; $display("FAIL bp_hold%0d: rsp_ready=%b rsp_valid=%b expected 0 1", c, frr, rv0);
                end
            end
            if (rv0 && rr[0]) got.push_back(rd0);
            if (frr) idx++;
            cyc();
        end
        frv = 1'b0; rr = '0;
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d beats expected 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== bd[i]) begin
                errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, got[i], bd[i]);
            end
        end
        idle();
    endtask

    task automatic test_orphan();
        do_reset();
        frv = 1'b1; frd = {$urandom, $urandom, $urandom, $urandom}; rr = 2'b11; settle();
        checks++;
        if (frr !== 1'b1 || {rv1, rv0} !== 2'b00 || err !== 1'b0) begin
            errors++; $display("FAIL orphan_consume: rsp_ready=%b valid=%b err=%b expected 1 00 0", frr, {rv1, rv0}, err);
        end
        cyc(); frv = 1'b0; settle();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL orphan_set: err=%b expected 1", err);
        end
        repeat (3) cyc();
        settle();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL orphan_sticky: err=%b expected 1", err);
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        fcr = 1'b1; cv = 2'b01; ct[0] = CMD_RD; ca[0] = 27'h10; settle();
        checks++;
        if (cr0 !== 1'b1) begin
            errors++; $display("FAIL rmb_read: ready=%b expected 1", cr0);
        end
        cyc();
        cv = 2'b10; ct[1] = CMD_WT; ca[1] = 27'h600; cb[1] = 6'd3;
        for (int b = 0; b < 2; b++) begin
            cd[1] = {$urandom, $urandom, $urandom, $urandom}; settle();
            checks++;
            if (cr1 !== 1'b1) begin
                errors++; $display("FAIL rmb_beat%0d: ready=%b expected 1", b, cr1);
            end
            cyc();
        end
        idle(); rstn = 1'b0; settle();
        checks++;
        if ({fcv, cr0, cr1, rv0, rv1, frr, err} !== 7'b0) begin
            errors++; $display("FAIL rmb_outputs: got %b expected 0000000", {fcv, cr0, cr1, rv0, rv1, frr, err});
        end
        cyc(); rstn = 1'b1; cyc();
        frv = 1'b1; frd = {$urandom, $urandom, $urandom, $urandom}; rr = 2'b11; settle();
        checks++;
        if ({rv1, rv0, frr} !== 3'b001) begin
            errors++; $display("FAIL rmb_stale_beat: valid=%b ready=%b expected 00 1", {rv1, rv0}, frr);
        end
        cyc(); frv = 1'b0; rr = '0;
        cv = 2'b11; ct = 2'b11; ca[0] = 27'h111; ca[1] = 27'h222; cb[1] = '0; fcr = 1'b1; settle();
        checks++;
        if ({cr1, cr0} !== 2'b01 || err !== 1'b1) begin
            errors++; $display("FAIL rmb_first_grant: ready=%b err=%b expected 01 1", {cr1, cr0}, err);
        end
        cyc(); idle();
    endtask

    // Model: per-requester commands counted in beats, a queue of outstanding reads,
    // and the arbitration rules applied to whoever is valid this cycle.
    task automatic test_random();
        localparam int NCMD = 40;
        logic act [2];
        int   done [2];
        int   issued [2];
        int   ot_id [$];
        int   ot_left [$];
        int   owed = 0;
        int   model_last = 1;
        int   cycles = 0;
        int   w, lock_id, h;
        logic wv, exp_hs, exp_frr, r_hs;
        logic [1:0] exp_rdy, exp_rv;
        do_reset();
        for (int i = 0; i < 2; i++) begin act[i] = 1'b0; done[i] = 0; issued[i] = 0; end
        while (!(issued[0] == NCMD && issued[1] == NCMD && ot_id.size() == 0 && !frv)) begin
            if (cycles > 20000) begin
                errors++; $display("FAIL random_timeout: issued %0d/%0d outstanding %0d", issued[0], issued[1], ot_id.size());
                break;
            end
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && issued[i] < NCMD) begin
                    act[i] = 1'b1; done[i] = 0;
                    ct[i] = 1'($urandom_range(0, 1));
                    cb[i] = BCNT_W'(ct[i] == CMD_RD ? $urandom_range(0, 2) : $urandom_range(0, 3));
                    ca[i] = ADDR_W'($urandom);
                end
                cv[i] = act[i] && ($urandom_range(0, 3) != 0);
                cd[i] = {$urandom, $urandom, $urandom, $urandom};
                cm[i] = MASK_W'($urandom);
            end
            fcr = ($urandom_range(0, 3) != 0);
            if (!frv && owed > 0 && $urandom_range(0, 2) != 0) begin
                frv = 1'b1; frd = {$urandom, $urandom, $urandom, $urandom};
            end
            rr = 2'($urandom);
            settle();

            lock_id = -1;
            for (int i = 0; i < 2; i++)
                if (act[i] && ct[i] == CMD_WT && done[i] > 0) lock_id = i;
            if (lock_id >= 0) w = lock_id;
            else if (cv == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = 1 - model_last;
`endif
            end else w = cv[1] ? 1 : 0;
            wv = cv[w];
            exp_hs = wv && !(ct[w] == CMD_RD && ot_id.size() == OT_DEPTH) && fcr;
            exp_rdy = exp_hs ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({cr1, cr0} !== exp_rdy) begin
                errors++; $display("FAIL rnd_cmd_ready cyc%0d: got %b expected %b", cycles, {cr1, cr0}, exp_rdy);
            end
            if (exp_hs) begin
                checks++;
                if ({fct, fca, fcb, fcd, fcm} !== {ct[w], ca[w], cb[w], cd[w], cm[w]}) begin
                    errors++; $display("FAIL rnd_cmd_fields cyc%0d: got addr=%h bcnt=%0d expected rq%0d addr=%h bcnt=%0d", cycles, fca, fcb, w, ca[w], cb[w]);
                end
            end

            if (ot_id.size() == 0) begin
                exp_rv = 2'b00; exp_frr = frv;
            end else begin
                h = ot_id[0];
                exp_rv = frv ? ((h == 1) ? 2'b10 : 2'b01) : 2'b00;
                exp_frr = rr[h];
            end
            checks++;
            if ({rv1, rv0, frr} !== {exp_rv, exp_frr}) begin
                errors++; $display("FAIL rnd_rsp_steer cyc%0d: valid=%b ready=%b expected %b %b", cycles, {rv1, rv0}, frr, exp_rv, exp_frr);
            end
            if (frv) begin
                checks++;
                if (rd0 !== frd || rd1 !== frd) begin
                    errors++; $display("FAIL rnd_rsp_data cyc%0d: got %h %h expected %h", cycles, rd0, rd1, frd);
                end
            end
            r_hs = frv && exp_frr && ot_id.size() != 0;

            cyc();
            cycles++;
            if (exp_hs) begin
                done[w]++;
                if (ct[w] == CMD_RD) begin
                    ot_id.push_back(w); ot_left.push_back(int'(cb[w]) + 1);
                    owed += int'(cb[w]) + 1;
                    act[w] = 1'b0; issued[w]++; model_last = w;
                end else if (done[w] == int'(cb[w]) + 1) begin
                    act[w] = 1'b0; issued[w]++; model_last = w;
                end
            end
            if (r_hs) begin
                owed--; frv = 1'b0;
                ot_left[0] = ot_left[0] - 1;
                if (ot_left[0] == 0) begin
                    void'(ot_id.pop_front()); void'(ot_left.pop_front());
                end
            end
        end
        settle();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL rnd_no_orphan: err=%b expected 0", err);
        end
        idle();
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        test_reset();
        test_contention();
        test_locked_write();
        test_tracker_full();
        test_rsp_backpressure();
        test_orphan();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
